// File: rtl/decode_ctrl_pipe_pkg.sv
// ctrl_pkg: shared types for the RV32I decode/control stage.
//   aluctrl_e   - ALU operation encoding driven into EX
//   immsrc_e    - immediate format selector for the EX immediate generator
//   resultsrc_e - writeback source select
//   ctrl_t      - bundle of decoded control fields carried through ID/EX
package ctrl_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLTU  = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_PASSB = 4'd10
    } aluctrl_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4
    } immsrc_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_MEM = 2'd1,
        RES_PC4 = 2'd2
    } resultsrc_e;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_IALU   = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;

    typedef struct packed {
        logic       regwrite;
        logic       memwrite;
        logic       alusrc;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       illegal;
        aluctrl_e   aluctrl;
        immsrc_e    immsrc;
        resultsrc_e resultsrc;
        logic [2:0] funct3;
    } ctrl_t;

    // ALU op for the R / I-ALU groups. instr[30] selects SUB only on the
    // R path (on I-type it is an immediate bit), but selects SRA on both.
    function automatic aluctrl_e alu_op(input logic [2:0] f3, input logic b30,
                                        input logic is_r);
        aluctrl_e op;
        case (f3)
            3'd0:    op = (is_r && b30) ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = b30 ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_ctrl_pipe_instr_decoder.sv
// instr_decoder: purely combinational RV32I opcode/funct decode.
//   instr    in  32-bit instruction word
//   ctrl     out decoded control fields
//   rd/rs1/rs2 out register indices (rd zeroed when nothing is written)
//   rs1_used/rs2_used out source-operand use flags for hazard detection
module instr_decoder
    import ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [31:0]           instr,
    output ctrl_t                 ctrl,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [REG_ADDR_W-1:0] rs1,
    output logic [REG_ADDR_W-1:0] rs2,
    output logic                  rs1_used,
    output logic                  rs2_used
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign f3          = instr[14:12];
    assign rs1         = REG_ADDR_W'(instr[19:15]);
    assign rs2         = REG_ADDR_W'(instr[24:20]);
    assign unused_bits = ^{instr[31], instr[29:25]};

    always_comb begin
        ctrl     = '0;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl.regwrite = 1'b1;
                ctrl.aluctrl  = alu_op(f3, instr[30], 1'b1);
                rs1_used      = 1'b1;
                rs2_used      = 1'b1;
            end
            OP_IALU: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.immsrc   = IMM_I;
                ctrl.aluctrl  = alu_op(f3, instr[30], 1'b0);
                rs1_used      = 1'b1;
            end
            OP_LOAD: begin
                ctrl.regwrite  = 1'b1;
                ctrl.alusrc    = 1'b1;
                ctrl.resultsrc = RES_MEM;
                ctrl.immsrc    = IMM_I;
                ctrl.funct3    = f3;
                rs1_used       = 1'b1;
            end
            OP_STORE: begin
                ctrl.memwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.immsrc   = IMM_S;
                ctrl.funct3   = f3;
                rs1_used      = 1'b1;
                rs2_used      = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.branch  = 1'b1;
                ctrl.aluctrl = ALU_SUB;
                ctrl.immsrc  = IMM_B;
                ctrl.funct3  = f3;
                rs1_used     = 1'b1;
                rs2_used     = 1'b1;
            end
            OP_JAL: begin
                ctrl.regwrite  = 1'b1;
                ctrl.jump      = 1'b1;
                ctrl.immsrc    = IMM_J;
                ctrl.resultsrc = RES_PC4;
            end
            OP_JALR: begin
                ctrl.regwrite  = 1'b1;
                ctrl.jump      = 1'b1;
                ctrl.jalr      = 1'b1;
                ctrl.alusrc    = 1'b1;
                ctrl.immsrc    = IMM_I;
                ctrl.resultsrc = RES_PC4;
                rs1_used       = 1'b1;
            end
            OP_LUI: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.immsrc   = IMM_U;
                ctrl.aluctrl  = ALU_PASSB;
            end
            OP_AUIPC: begin
                // operand A is ex_pc; EX picks that from the opcode-free
                // combination alusrc=1 / immsrc=U / aluctrl=ADD
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.immsrc   = IMM_U;
                ctrl.aluctrl  = ALU_ADD;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

    // rd bits of S/B encodings are immediate bits; hide them so a store or
    // branch never looks like a writer to downstream forwarding logic
    assign rd = ctrl.regwrite ? REG_ADDR_W'(instr[11:7]) : '0;

endmodule

// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe: RV32I decode/control stage with ID/EX register,
// load-use stall FSM and EX flush.
//   clk, rst_n          clock, async active-low reset
//   if_valid/instr/pc   instruction from IF (held while id_ready is low)
//   flush               EX redirect, kills ID/EX and any pending stall
//   id_ready            ID accepts this cycle
//   ex_*                registered decode of the ID/EX instruction
module decode_ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int ALUCTRL_W    = 4,
    parameter int STALL_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_valid,
    input  logic [XLEN-1:0]       instr,
    input  logic [XLEN-1:0]       pc,
    input  logic                  flush,
    output logic                  id_ready,
    output logic                  ex_valid,
    output logic                  ex_regwrite,
    output logic                  ex_memwrite,
    output logic                  ex_alusrc,
    output logic                  ex_branch,
    output logic                  ex_jump,
    output logic                  ex_jalr,
    output logic                  ex_illegal,
    output logic [ALUCTRL_W-1:0]  ex_aluctrl,
    output logic [2:0]            ex_immsrc,
    output logic [1:0]            ex_resultsrc,
    output logic [2:0]            ex_funct3,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [REG_ADDR_W-1:0] ex_rs1,
    output logic [REG_ADDR_W-1:0] ex_rs2,
    output logic [XLEN-1:0]       ex_pc
);

    // counter holds remaining STALL cycles minus one
    localparam int CNT_W = (STALL_CYCLES > 2) ? $clog2(STALL_CYCLES - 1) : 1;

    typedef enum logic {S_RUN, S_STALL} state_e;

    state_e                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;

    ctrl_t                 dec;
    logic [REG_ADDR_W-1:0] dec_rd, dec_rs1, dec_rs2;
    logic                  rs1_used, rs2_used;

    ctrl_t                 ex_q;
    logic                  hazard, transfer;

    instr_decoder #(.REG_ADDR_W(REG_ADDR_W)) u_dec (
        .instr    (instr[31:0]),
        .ctrl     (dec),
        .rd       (dec_rd),
        .rs1      (dec_rs1),
        .rs2      (dec_rs2),
        .rs1_used (rs1_used),
        .rs2_used (rs2_used)
    );

    // bubbles carry rd = 0, so they can never trip this
    assign hazard = if_valid && ex_valid && (ex_q.resultsrc == RES_MEM) &&
                    (ex_rd != '0) &&
                    ((rs1_used && (dec_rs1 == ex_rd)) ||
                     (rs2_used && (dec_rs2 == ex_rd)));

    assign transfer = if_valid && id_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        id_ready  = 1'b0;
        if (flush) begin
            state_nxt = S_RUN;
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_RUN: begin
                    id_ready = !hazard;
                    // the hazard cycle itself is the first bubble
                    if (hazard && (STALL_CYCLES > 1)) begin
                        state_nxt = S_STALL;
                        cnt_nxt   = CNT_W'(STALL_CYCLES - 2);
                    end
                end
                default: begin
                    if (cnt == '0) state_nxt = S_RUN;
                    else           cnt_nxt   = cnt - 1'b1;
                end
            endcase
        end
    end

    // ID/EX register: a non-transfer cycle (incl. flush and stall) loads
    // an all-zero bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_q     <= '0;
            ex_rd    <= '0;
            ex_rs1   <= '0;
            ex_rs2   <= '0;
            ex_pc    <= '0;
        end else if (transfer) begin
            ex_valid <= 1'b1;
            ex_q     <= dec;
            ex_rd    <= dec_rd;
            ex_rs1   <= dec_rs1;
            ex_rs2   <= dec_rs2;
            ex_pc    <= pc;
        end else begin
            ex_valid <= 1'b0;
            ex_q     <= '0;
            ex_rd    <= '0;
            ex_rs1   <= '0;
            ex_rs2   <= '0;
            ex_pc    <= '0;
        end
    end

    assign ex_regwrite  = ex_q.regwrite;
    assign ex_memwrite  = ex_q.memwrite;
    assign ex_alusrc    = ex_q.alusrc;
    assign ex_branch    = ex_q.branch;
    assign ex_jump      = ex_q.jump;
    assign ex_jalr      = ex_q.jalr;
    assign ex_illegal   = ex_q.illegal;
    assign ex_aluctrl   = ALUCTRL_W'(ex_q.aluctrl);
    assign ex_immsrc    = ex_q.immsrc;
    assign ex_resultsrc = ex_q.resultsrc;
    assign ex_funct3    = ex_q.funct3;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed bench: a STALL_CYCLES=1 instance (a*) and a STALL_CYCLES=3
// instance (b*) share the same IF/flush/reset drive; each test resets
// both and checks the instance relevant to it.
module tb_decode_ctrl_pipe;

    logic        clk = 1'b0;
    logic        rst_n, if_valid, flush;
    logic [31:0] instr, pc;

    logic        a_rdy, a_vld, a_rw, a_mw, a_as, a_br, a_jp, a_jr, a_il;
    logic [3:0]  a_alu;
    logic [2:0]  a_imm, a_f3;
    logic [1:0]  a_res;
    logic [4:0]  a_rd, a_rs1, a_rs2;
    logic [31:0] a_pc;

    logic        b_rdy, b_vld, b_rw, b_mw, b_as, b_br, b_jp, b_jr, b_il;
    logic [3:0]  b_alu;
    logic [2:0]  b_imm, b_f3;
    logic [1:0]  b_res;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [31:0] b_pc;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    decode_ctrl_pipe #(.STALL_CYCLES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .instr(instr), .pc(pc),
        .flush(flush), .id_ready(a_rdy), .ex_valid(a_vld), .ex_regwrite(a_rw),
        .ex_memwrite(a_mw), .ex_alusrc(a_as), .ex_branch(a_br), .ex_jump(a_jp),
        .ex_jalr(a_jr), .ex_illegal(a_il), .ex_aluctrl(a_alu), .ex_immsrc(a_imm),
        .ex_resultsrc(a_res), .ex_funct3(a_f3), .ex_rd(a_rd), .ex_rs1(a_rs1),
        .ex_rs2(a_rs2), .ex_pc(a_pc)
    );

    decode_ctrl_pipe #(.STALL_CYCLES(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .instr(instr), .pc(pc),
        .flush(flush), .id_ready(b_rdy), .ex_valid(b_vld), .ex_regwrite(b_rw),
        .ex_memwrite(b_mw), .ex_alusrc(b_as), .ex_branch(b_br), .ex_jump(b_jp),
        .ex_jalr(b_jr), .ex_illegal(b_il), .ex_aluctrl(b_alu), .ex_immsrc(b_imm),
        .ex_resultsrc(b_res), .ex_funct3(b_f3), .ex_rd(b_rd), .ex_rs1(b_rs1),
        .ex_rs2(b_rs2), .ex_pc(b_pc)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; if_valid = 1'b0; flush = 1'b0; instr = '0; pc = '0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic issue(input logic [31:0] i, input logic [31:0] p);
        if_valid = 1'b1; instr = i; pc = p;
        step();
        if_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_valid = 1'b0; flush = 1'b0; instr = '0; pc = '0;
        #2;
        n_chk++; if (a_vld !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", a_vld); end
        n_chk++; if ({a_rw, a_mw, a_as, a_br, a_jp, a_jr, a_il} !== 7'b0) begin n_fail++; $display("FAIL reset_flags got %b want 0", {a_rw, a_mw, a_as, a_br, a_jp, a_jr, a_il}); end
        n_chk++; if ({a_alu, a_imm, a_res, a_f3, a_rd, a_rs1, a_rs2, a_pc} !== '0) begin n_fail++; $display("FAIL reset_fields got nonzero"); end
        n_chk++; if (a_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b want 1", a_rdy); end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_alu_decode();
        do_reset();
        issue(32'h002081B3, 32'h100);   // add x3,x1,x2
        n_chk++; if (a_vld !== 1'b1 || a_rw !== 1'b1) begin n_fail++; $display("FAIL add_vld_rw got %0b%0b want 11", a_vld, a_rw); end
        n_chk++; if (a_alu !== 4'd0 || a_as !== 1'b0) begin n_fail++; $display("FAIL add_alu got %0d/%0b want 0/0", a_alu, a_as); end
        n_chk++; if (a_rd !== 5'd3 || a_rs1 !== 5'd1 || a_rs2 !== 5'd2) begin n_fail++; $display("FAIL add_regs got %0d %0d %0d want 3 1 2", a_rd, a_rs1, a_rs2); end
        n_chk++; if (a_pc !== 32'h100 || a_res !== 2'd0) begin n_fail++; $display("FAIL add_pc got %0h/%0d want 100/0", a_pc, a_res); end
        step();
        n_chk++; if (a_vld !== 1'b0) begin n_fail++; $display("FAIL idle_bubble got %0b want 0", a_vld); end
        issue(32'h402081B3, 32'h104);   // sub x3,x1,x2
        n_chk++; if (a_alu !== 4'd1) begin n_fail++; $display("FAIL sub_alu got %0d want 1", a_alu); end
        issue(32'h40008193, 32'h108);   // addi x3,x1,1024 (bit30 set, still ADD)
        n_chk++; if (a_alu !== 4'd0 || a_as !== 1'b1 || a_imm !== 3'd0) begin n_fail++; $display("FAIL addi_b30 got %0d/%0b/%0d want 0/1/0", a_alu, a_as, a_imm); end
        issue(32'h4010D193, 32'h10C);   // srai x3,x1,1
        n_chk++; if (a_alu !== 4'd9) begin n_fail++; $display("FAIL srai_alu got %0d want 9", a_alu); end
    endtask

    task automatic test_other_decode();
        do_reset();
        issue(32'h00209463, 32'h200);   // bne x1,x2,8
        n_chk++; if (a_br !== 1'b1 || a_f3 !== 3'b001 || a_alu !== 4'd1 || a_imm !== 3'd2 || a_rw !== 1'b0) begin n_fail++; $display("FAIL bne got br%0b f3%0d alu%0d imm%0d rw%0b want 1 1 1 2 0", a_br, a_f3, a_alu, a_imm, a_rw); end
        issue(32'h0020A223, 32'h204);   // sw x2,4(x1)
        n_chk++; if (a_mw !== 1'b1 || a_as !== 1'b1 || a_imm !== 3'd1 || a_rw !== 1'b0) begin n_fail++; $display("FAIL sw got mw%0b as%0b imm%0d rw%0b want 1 1 1 0", a_mw, a_as, a_imm, a_rw); end
        issue(32'h000280E7, 32'h208);   // jalr x1,0(x5)
        n_chk++; if ({a_jp, a_jr, a_as, a_rw} !== 4'b1111 || a_imm !== 3'd0 || a_res !== 2'd2 || a_rd !== 5'd1) begin n_fail++; $display("FAIL jalr got %b imm%0d res%0d rd%0d want 1111 0 2 1", {a_jp, a_jr, a_as, a_rw}, a_imm, a_res, a_rd); end
        issue(32'h123453B7, 32'h20C);   // lui x7,0x12345
        n_chk++; if (a_alu !== 4'd10 || a_imm !== 3'd4 || a_as !== 1'b1 || a_rw !== 1'b1) begin n_fail++; $display("FAIL lui got alu%0d imm%0d as%0b rw%0b want 10 4 1 1", a_alu, a_imm, a_as, a_rw); end
        issue(32'hFFFFFFFF, 32'h210);   // unknown opcode
        n_chk++; if (a_il !== 1'b1 || a_rw !== 1'b0 || a_mw !== 1'b0 || a_vld !== 1'b1) begin n_fail++; $display("FAIL illegal got il%0b rw%0b mw%0b vld%0b want 1 0 0 1", a_il, a_rw, a_mw, a_vld); end
    endtask

    task automatic test_load_use_1();
        do_reset();
        issue(32'h0000A283, 32'h300);   // lw x5,0(x1)
        n_chk++; if (a_res !== 2'd1 || a_rd !== 5'd5) begin n_fail++; $display("FAIL lw got res%0d rd%0d want 1 5", a_res, a_rd); end
        if_valid = 1'b1; instr = 32'h00028333; pc = 32'h304;   // add x6,x5,x0
        #1;
        n_chk++; if (a_rdy !== 1'b0) begin n_fail++; $display("FAIL lu1_stall got %0b want 0", a_rdy); end
        step();
        n_chk++; if (a_vld !== 1'b0 || a_rdy !== 1'b1) begin n_fail++; $display("FAIL lu1_bubble got vld%0b rdy%0b want 0 1", a_vld, a_rdy); end
        step();
        if_valid = 1'b0;
        n_chk++; if (a_vld !== 1'b1 || a_rs1 !== 5'd5 || a_rd !== 5'd6 || a_pc !== 32'h304) begin n_fail++; $display("FAIL lu1_issue got vld%0b rs1%0d rd%0d pc%0h want 1 5 6 304", a_vld, a_rs1, a_rd, a_pc); end
    endtask

    task automatic test_load_use_3();
        int bubbles = 0;
        bit done = 0;
        do_reset();
        issue(32'h0000A283, 32'h400);
        if_valid = 1'b1; instr = 32'h00028333; pc = 32'h404;
        #1;
        for (int c = 0; c < 10 && !done; c++) begin
            if (b_rdy) begin
                step();
                done = 1;
            end else begin
                bubbles++;
                step();
                n_chk++; if (b_vld !== 1'b0) begin n_fail++; $display("FAIL lu3_bubble%0d got vld %0b want 0", bubbles, b_vld); end
            end
        end
        if_valid = 1'b0;
        n_chk++; if (!done) begin n_fail++; $display("FAIL lu3_timeout got no accept want accept"); end
        n_chk++; if (bubbles != 3) begin n_fail++; $display("FAIL lu3_count got %0d want 3", bubbles); end
        n_chk++; if (b_vld !== 1'b1 || b_rs1 !== 5'd5) begin n_fail++; $display("FAIL lu3_issue got vld%0b rs1%0d want 1 5", b_vld, b_rs1); end
    endtask

    task automatic test_flush_stall();
        do_reset();
        issue(32'h0000A283, 32'h500);
        if_valid = 1'b1; instr = 32'h00028333; pc = 32'h504;
        step();                          // now in STALL, second stall cycle
        n_chk++; if (b_rdy !== 1'b0) begin n_fail++; $display("FAIL fl_stall got %0b want 0", b_rdy); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        n_chk++; if (b_vld !== 1'b0 || b_rdy !== 1'b1) begin n_fail++; $display("FAIL fl_after got vld%0b rdy%0b want 0 1", b_vld, b_rdy); end
        step();
        if_valid = 1'b0;
        n_chk++; if (b_vld !== 1'b1 || b_rd !== 5'd6) begin n_fail++; $display("FAIL fl_resume got vld%0b rd%0d want 1 6", b_vld, b_rd); end
        // flush while IF offers an instruction kills the transfer
        if_valid = 1'b1; instr = 32'h002081B3; pc = 32'h508; flush = 1'b1;
        #1;
        n_chk++; if (a_rdy !== 1'b0) begin n_fail++; $display("FAIL fl_ready got %0b want 0", a_rdy); end
        step();
        flush = 1'b0; if_valid = 1'b0;
        n_chk++; if (a_vld !== 1'b0 || a_rw !== 1'b0) begin n_fail++; $display("FAIL fl_kill got vld%0b rw%0b want 0 0", a_vld, a_rw); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        issue(32'h0000A283, 32'h600);
        if_valid = 1'b1; instr = 32'h00028333; pc = 32'h604;
        step();                          // dut_b in STALL
        rst_n = 1'b0;
        #1;
        n_chk++; if (b_vld !== 1'b0 || b_res !== 2'd0 || b_rd !== 5'd0 || b_pc !== 32'h0 || b_rw !== 1'b0) begin n_fail++; $display("FAIL rms_clear got vld%0b res%0d rd%0d pc%0h want 0", b_vld, b_res, b_rd, b_pc); end
        #2;
        rst_n = 1'b1;
        #1;
        n_chk++; if (b_rdy !== 1'b1) begin n_fail++; $display("FAIL rms_ready got %0b want 1", b_rdy); end
        step();
        if_valid = 1'b0;
        n_chk++; if (b_vld !== 1'b1 || b_rd !== 5'd6 || b_pc !== 32'h604) begin n_fail++; $display("FAIL rms_accept got vld%0b rd%0d pc%0h want 1 6 604", b_vld, b_rd, b_pc); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] seq [3];
        logic [4:0]  rds [3];
        seq[0] = 32'h002081B3; rds[0] = 5'd3;   // add x3,x1,x2
        seq[1] = 32'h00308213; rds[1] = 5'd4;   // addi x4,x1,3
        seq[2] = 32'h0041A2B3; rds[2] = 5'd5;   // slt x5,x3,x4
        do_reset();
        for (int k = 0; k < 3; k++) begin
            if_valid = 1'b1; instr = seq[k]; pc = 32'h700 + 32'(k * 4);
            step();
            n_chk++; if (a_vld !== 1'b1 || a_rd !== rds[k] || a_pc !== 32'h700 + 32'(k * 4)) begin n_fail++; $display("FAIL b2b_%0d got vld%0b rd%0d pc%0h want 1 %0d", k, a_vld, a_rd, a_pc, rds[k]); end
        end
        if_valid = 1'b0;
        n_chk++; if (a_alu !== 4'd5) begin n_fail++; $display("FAIL b2b_slt got %0d want 5", a_alu); end
    endtask

    initial begin
        test_reset();
        test_alu_decode();
        test_other_decode();
        test_load_use_1();
        test_load_use_3();
        test_flush_stall();
        test_reset_mid_stall();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_ctrl_pipe.md
# decode_ctrl_pipe

Pipelined RV32I decode/control stage that replaces the single-cycle control decoder. It sits between fetch (IF) and execute (EX) and decodes each accepted instruction into control fields. Those fields are registered into the ID/EX pipeline register. The block also covers the full RV32I branch, shift and compare set, detects load-use hazards and inserts a parametrised number of bubbles, and honours a flush from EX on a taken branch or jump.

## Interface
- XLEN, 32, instruction/PC width
- REG_ADDR_W, 5, register index width
- ALUCTRL_W, 4, ALU control width (must be at least 4)
- STALL_CYCLES, 1, bubbles per load-use hazard (at least 1)

One clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  IF presents an instruction
- instr  in  XLEN  instruction word
- pc  in  XLEN  instruction address
- flush  in  1  EX redirect; kill the ID/EX contents
- id_ready  out  1  ID accepts; the transfer happens when if_valid and id_ready are both high
- ex_valid  out  1  ID/EX holds a real instruction
- ex_regwrite, ex_memwrite, ex_alusrc, ex_branch, ex_jump, ex_jalr, ex_illegal  out  1 each  control flags
- ex_aluctrl  out  ALUCTRL_W  ALU operation
- ex_immsrc  out  3  immediate format
- ex_resultsrc  out  2  writeback select: 0 = ALU, 1 = memory, 2 = PC+4
- ex_funct3  out  3  branch, load and store subtype
- ex_rd, ex_rs1, ex_rs2  out  REG_ADDR_W each  register indices
- ex_pc  out  XLEN  PC of the ID/EX instruction

## Operation
- **Decode (combinational, from instr):**
  - R/I-ALU: regwrite = 1. ALU op comes from funct3 plus instr[30]. SUB applies only on the R-type path; SRA applies on both paths.
  - Load: alusrc = 1, resultsrc = 1, immsrc = I.
  - Store: memwrite = 1, alusrc = 1, immsrc = S, regwrite = 0.
  - Branch: branch = 1, aluctrl = SUB, immsrc = B, funct3 passed through.
  - JAL: jump = 1, immsrc = J, resultsrc = 2, regwrite = 1.
  - JALR: as JAL, plus jalr = 1, immsrc = I, alusrc = 1.
  - LUI: aluctrl = PASSB, immsrc = U, alusrc = 1, regwrite = 1.
  - AUIPC: aluctrl = ADD, immsrc = U; the EX operand-A mux selects ex_pc.
  - Unknown opcode: illegal = 1 and all write enables 0.
- **Register use:**
  - rs1 is used by R, I-ALU, load, store, branch and JALR.
  - rs2 is used by R, store and branch.
- **Hazard condition:** ex_valid & (ex_resultsrc == 1) & (ex_rd != 0) & ((rs1 used & rs1 == ex_rd) | (rs2 used & rs2 == ex_rd)), evaluated while if_valid is high.
- **FSM states:**
  - RUN: id_ready = ~hazard. On a transfer, ID/EX loads the decoded fields with ex_valid = 1. With no transfer, ID/EX loads a bubble (ex_valid = 0 and all enables 0).
  - RUN to STALL: on a hazard with STALL_CYCLES > 1; the counter loads STALL_CYCLES - 2.
  - STALL: id_ready = 0 and a bubble is inserted each cycle. The counter decrements; the FSM returns to RUN in the cycle after the counter reads 0.
- **Flush:** flush has priority over everything else.
  - id_ready = 0 in the flush cycle.
  - Next cycle: ex_valid = 0, state = RUN, counter = 0.
  - Flush simultaneous with a hazard or with STALL: the flush wins.
- **Bubble content:** ex_rd, ex_rs1 and ex_rs2 are forced to 0 on a bubble, so a bubble never matches a hazard.

## Timing
- **Latency:** one cycle from a transfer to the ex_* outputs.
- **Reset:** all ex_* outputs are 0, state = RUN, counter = 0. id_ready follows its combinational definition (high when no hazard). Reset asserted mid-stall abandons the stall immediately.
- **Bubbles per hazard:** exactly STALL_CYCLES cycles with id_ready low, then the dependent instruction is accepted.
- **Input hold:** IF must hold instr and pc while id_ready is low.

## Structure
- **Package ctrl_pkg:**
  - aluctrl_e: ADD = 0, SUB = 1, AND = 2, OR = 3, XOR = 4, SLT = 5, SLTU = 6, SLL = 7, SRL = 8, SRA = 9, PASSB = 10.
  - immsrc_e: I = 0, S = 1, B = 2, J = 3, U = 4.
  - resultsrc_e as defined above.
  - Opcode localparams.
- **Sub-module instr_decoder:** purely combinational opcode/funct decode. decode_ctrl_pipe holds the hazard logic, the FSM, the counter and the ID/EX register.

## Test plan
- **ALU decode:** 0x002081B3 (add x3,x1,x2) -> next cycle ex_valid = 1, regwrite = 1, aluctrl = ADD, alusrc = 0, ex_rd = 3.
- **Load-use stall:** 0x0000A283 (lw x5,0(x1)) then 0x00028333 (add x6,x5,x0).
  - id_ready is 0 for one cycle and one bubble is inserted.
  - The add then issues with ex_rs1 = 5.
  - With STALL_CYCLES = 3: exactly 3 bubbles.
- **Branch decode:** 0x00209463 (bne x1,x2,8) -> branch = 1, funct3 = 001, aluctrl = SUB, immsrc = B, regwrite = 0.
- **Flush during stall:** flush asserted in the second stall cycle (STALL_CYCLES = 3) -> next cycle ex_valid = 0, state RUN, id_ready = 1.
- **Illegal opcode:** 0xFFFFFFFF -> ex_illegal = 1, regwrite = 0, memwrite = 0.
- **Reset mid-stall:** reset while in STALL -> all ex_* outputs 0 and state RUN. The next hazard-free instruction is accepted on the first clock after reset is released.
